tpu_axil_cmd_slave: RTL and testbench
=====================================

Name: tpu_axil_cmd_slave

Overview:
AXI4-Lite slave register block sitting directly behind the PS-side AXI master. It terminates the AXI4-Lite master's sequential 4-register write/read traffic. It assembles 64-bit TPU instructions from two data registers and pushes them into an internal command FIFO. A valid/ready command port drains the FIFO into the downstream TPU controller.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, AXI address width; word index = ADDR[3:2].
FIFO_DEPTH, 8, command FIFO entries; power of 2, 2..128.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
S_AXI_BRESP  out  2  OKAY=00, SLVERR=10.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  always 00.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
cmd_data  out  64  FIFO head instruction.
cmd_valid  out  1  FIFO non-empty.
cmd_ready  in  1  consumer accepts head.

Behaviour:
- Reset (ARESETN low, async): all AXI ready/valid outputs 0; BRESP, RDATA 0; REG0, REG1, REG3 = 0; overflow = 0; FIFO emptied, so cmd_valid = 0. Any in-flight transaction is dropped with no response.
- Register map:
  - 0x0 INST_LO: RW.
  - 0x4 INST_HI: RW.
  - 0x8 STATUS: RO. [7:0] count, [8] empty, [9] full, [31] overflow sticky. Writing with WDATA[31]=1 and WSTRB[3]=1 clears overflow; other write bits ignored.
  - 0xC CMD: RW storage; every write also pushes {REG1,REG0}.
- RW registers honour WSTRB per byte.
- Write channel:
  - Cycle N: AWVALID & WVALID both high, AWREADY low, BVALID low.
  - Cycle N+1: AWREADY = WREADY = 1 for exactly one cycle; register updated at end of N+1.
  - Cycle N+2 onward: BVALID = 1, held until BREADY.
  - No new write is accepted while BVALID is high. AW without W, or W without AW, waits.
- Push on CMD write:
  - Pushed word uses REG0/REG1 values before this cycle.
  - The push happens regardless of WSTRB.
  - If the FIFO is full (registered count == FIFO_DEPTH at the start of the cycle), the push is rejected even if a pop occurs in the same cycle. In that case BRESP = 10, overflow is set, and REG3 is still updated.
  - Otherwise BRESP = 00.
- Read channel:
  - Cycle N: ARVALID high, ARREADY low, RVALID low.
  - Cycle N+1: ARREADY = 1 for one cycle; address is latched.
  - Cycle N+2: RVALID = 1 with RDATA; RDATA stays stable until RREADY.
  - No new read is accepted while RVALID is high. Read and write channels operate independently and concurrently.
  - A STATUS read sampled in the same cycle as a push or pop shows the pre-update value.
- FIFO:
  - cmd_valid = !empty; cmd_data = head, registered, with no combinational path from AXI.
  - Pop when cmd_valid & cmd_ready.
  - Push and pop in the same cycle (not full) leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width = clog2(FIFO_DEPTH)+1.
  - cmd_valid rises in the cycle after the push's handshake cycle.

Test Plan:
1. Reset: hold ARESETN low 200 ns, release → BVALID, RVALID, cmd_valid = 0; read 0x8 → 0x00000100.
2. RW and strobes:
   - Write 0x0=0x11223344 and 0x4=0xAABBCCDD, read back → exact values with RRESP=00.
   - Write 0x0=0xFFFFFFFF with WSTRB=0011 → readback 0x1122FFFF.
3. Push/pop: write 0xC=0x1 → BRESP=00, cmd_valid=1, cmd_data=0xAABBCCDD1122FFFF, STATUS=0x00000001. Pulse cmd_ready for 1 cycle → cmd_valid=0, STATUS=0x00000100.
4. Overflow:
   - cmd_ready=0, 9 CMD writes → writes 1-8 BRESP=00, write 9 BRESP=10, STATUS=0x80000208.
   - Write 0x8=0x80000000 with WSTRB=1000 → STATUS=0x00000208.
   - Drain 8 entries → order preserved and STATUS=0x00000100.
5. Backpressure:
   - BREADY low 5 cycles → BVALID held, AWREADY stays 0 for a queued second write.
   - RREADY low 5 cycles → RVALID held, RDATA stable.
   - Simultaneous push and pop at count=3 → count stays 3.
6. Reset mid-operation: 3 entries queued and a write outstanding, drop ARESETN → cmd_valid and BVALID go to 0 immediately. After release, STATUS=0x00000100 and REG0 reads 0.

Source files
------------

// File: rtl/tpu_axil_cmd_slave.sv
// AXI4-Lite register block that assembles 64-bit TPU instructions from two data
// registers and queues them in a command FIFO drained through a valid/ready port.
module tpu_axil_cmd_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [63:0]                       cmd_data,
  output logic                              cmd_valid,
  input  logic                              cmd_ready
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rstate_t;

  wstate_t         w_state_q;
  rstate_t         r_state_q;
  logic            awready_q;
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            arready_q;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   inst_lo_q;
  logic [DW-1:0]   inst_hi_q;
  logic [DW-1:0]   cmd_reg_q;
  logic            overflow_q;

  logic [63:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [63:0]     cmd_data_q;

  logic [1:0]      wr_idx;
  logic [1:0]      rd_idx;
  logic [DW-1:0]   wr_old;
  logic [DW-1:0]   wr_new;
  logic [DW-1:0]   status_w;
  logic [DW-1:0]   rd_mux;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [63:0]     push_data;
  logic [PW-1:0]   rd_ptr_d;
  logic [63:0]     head_d;
  logic            unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx = S_AXI_AWADDR[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign status_w   = {overflow_q, {(DW-11){1'b0}}, fifo_full, fifo_empty, 8'(count_q)};

  always_comb begin
    wr_old = '0;
    case (wr_idx)
      2'd0:    wr_old = inst_lo_q;
      2'd1:    wr_old = inst_hi_q;
      2'd3:    wr_old = cmd_reg_q;
      default: wr_old = '0;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte_merge
      assign wr_new[8*gi +: 8] = S_AXI_WSTRB[gi] ? S_AXI_WDATA[8*gi +: 8] : wr_old[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      2'd0:    rd_mux = inst_lo_q;
      2'd1:    rd_mux = inst_hi_q;
      2'd2:    rd_mux = status_w;
      default: rd_mux = cmd_reg_q;
    endcase
  end

  // Register updates happen in the single accept cycle, while AW/W are still held valid.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      inst_lo_q  <= '0;
      inst_hi_q  <= '0;
      cmd_reg_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_q <= 1'b1;
            w_state_q <= W_ACCEPT;
          end
        end
        W_ACCEPT: begin
          awready_q <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= 2'b00;
          w_state_q <= W_RESP;
          case (wr_idx)
            2'd0: inst_lo_q <= wr_new;
            2'd1: inst_hi_q <= wr_new;
            2'd2: begin
              if (S_AXI_WDATA[DW-1] && S_AXI_WSTRB[NB-1]) overflow_q <= 1'b0;
            end
            default: begin
              cmd_reg_q <= wr_new;
              if (fifo_full) begin
                overflow_q <= 1'b1;
                bresp_q    <= 2'b10;
              end
            end
          endcase
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            arready_q <= 1'b1;
            r_state_q <= R_ACCEPT;
          end
        end
        R_ACCEPT: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_mux;
          r_state_q <= R_DATA;
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never rescues a push.
  assign push      = (w_state_q == W_ACCEPT) && (wr_idx == 2'd3) && !fifo_full;
  assign pop       = cmd_valid && cmd_ready;
  assign push_data = {inst_hi_q, inst_lo_q};
  assign rd_ptr_d  = rd_ptr_q + PW'(pop);

  always_comb begin
    head_d = mem_q[rd_ptr_d];
    if (push && ((count_q - CW'(pop)) == '0)) head_d = push_data;
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_q + CW'(push) - CW'(pop);
      cmd_data_q <= head_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign cmd_valid     = !fifo_empty;
  assign cmd_data      = cmd_data_q;

endmodule

// File: tb/tb_tpu_axil_cmd_slave.sv
// Scoreboard bench for tpu_axil_cmd_slave: a queue-based register/FIFO model
// predicts every B, R and command response; a forked monitor checks them.
module tb_tpu_axil_cmd_slave;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [63:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;

  always #5 clk = ~clk;

  tpu_axil_cmd_slave #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
  );

  // Reference model: register file, overflow flag and the FIFO as a plain queue.
  logic [31:0] m_reg [4];
  bit          m_ovf;
  logic [63:0] m_fifo [$];
  logic [1:0]  exp_b [$];
  logic [31:0] exp_r [$];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_ovf = 1'b0;
    m_fifo.delete();
    exp_b.delete();
    exp_r.delete();
  endfunction

  function automatic logic [31:0] m_status();
    bit full_b, empty_b;
    full_b  = (m_fifo.size() == DEPTH);
    empty_b = (m_fifo.size() == 0);
    return {m_ovf, 21'd0, full_b, empty_b, 8'(m_fifo.size())};
  endfunction

  function automatic void model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    logic [31:0] merged;
    logic [1:0] resp;
    idx = int'(addr[3:2]);
    resp = 2'b00;
    merged = m_reg[idx];
    for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
    if (idx == 2) begin
      if (data[31] && strb[3]) m_ovf = 1'b0;
    end else if (idx == 3) begin
      if (m_fifo.size() == DEPTH) begin
        m_ovf = 1'b1;
        resp = 2'b10;
      end else begin
        m_fifo.push_back({m_reg[1], m_reg[0]});
      end
      m_reg[3] = merged;
    end else begin
      m_reg[idx] = merged;
    end
    exp_b.push_back(resp);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    logic [31:0] v;
    v = (addr[3:2] == 2'd2) ? m_status() : m_reg[addr[3:2]];
    exp_r.push_back(v);
    return v;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check64(name, {63'd0, act}, {63'd0, exp});
  endtask

  task automatic check_cmd_port();
    check1("cmd_valid", cmd_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) check64("cmd_head", cmd_data, m_fifo[0]);
  endtask

  task automatic start_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    check1("awready_idle", awready, 1'b0);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    model_write(addr, data, strb);
  endtask

  task automatic wait_aw(input bit chk_lat);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!awready && n < 100);
    if (chk_lat) check64("aw_latency", 64'(n), 64'd1);
    check1("awready_seen", awready, 1'b1);
    check1("wready_seen", wready, 1'b1);
  endtask

  task automatic end_write();
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check1("awready_pulse", awready, 1'b0);
    check1("bvalid_rise", bvalid, 1'b1);
    check_cmd_port();
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (bvalid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check1("bvalid_clear", bvalid, 1'b0);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    @(posedge clk); #1;
    start_write(addr, data, strb);
    wait_aw(1'b1);
    end_write();
    wait_b();
    $display("WR   addr=0x%0h data=0x%08h strb=%b fifo=%0d ovf=%0d", addr, data, strb, m_fifo.size(), m_ovf);
  endtask

  task automatic do_read(input logic [3:0] addr, input int hold);
    int n;
    logic [31:0] v;
    @(posedge clk); #1;
    check1("arready_idle", arready, 1'b0);
    araddr = addr; arvalid = 1'b1; rready = (hold == 0);
    v = model_read(addr);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!arready && n < 100);
    check64("ar_latency", 64'(n), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check1("arready_pulse", arready, 1'b0);
    check1("rvalid_rise", rvalid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check1("rvalid_hold", rvalid, 1'b1);
      check64("rdata_hold", {32'd0, rdata}, {32'd0, v});
    end
    rready = 1'b1;
    n = 0;
    while (rvalid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check1("rvalid_clear", rvalid, 1'b0);
    $display("RD   addr=0x%0h expect=0x%08h hold=%0d", addr, v, hold);
  endtask

  task automatic do_pop();
    @(posedge clk); #1;
    check_cmd_port();
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    check_cmd_port();
    $display("POP  fifo=%0d", m_fifo.size());
  endtask

  initial begin
    model_reset();
    fork
      begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (bvalid && bready) begin
            if (exp_b.size() == 0) check64("b_unexpected", 64'd1, 64'd0);
            else check64("bresp", {62'd0, bresp}, {62'd0, exp_b.pop_front()});
          end
          if (rvalid && rready) begin
            if (exp_r.size() == 0) check64("r_unexpected", 64'd1, 64'd0);
            else check64("rdata", {32'd0, rdata}, {32'd0, exp_r.pop_front()});
            check64("rresp", {62'd0, rresp}, 64'd0);
          end
          if (cmd_valid && cmd_ready) begin
            if (m_fifo.size() == 0) check64("cmd_unexpected", 64'd1, 64'd0);
            else check64("cmd_data", cmd_data, m_fifo.pop_front());
          end
        end
      end
    join_none

    // Reset
    #200;
    check1("rst_bvalid", bvalid, 1'b0);
    check1("rst_rvalid", rvalid, 1'b0);
    check1("rst_cmd_valid", cmd_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(4'h8, 0);

    // RW registers and byte strobes
    do_write(4'h0, 32'h11223344, 4'hF);
    do_write(4'h4, 32'hAABBCCDD, 4'hF);
    do_read(4'h0, 0);
    do_read(4'h4, 0);
    do_write(4'h0, 32'hFFFFFFFF, 4'b0011);
    do_read(4'h0, 0);

    // Single push / pop
    do_write(4'hC, 32'h1, 4'hF);
    do_read(4'h8, 0);
    do_pop();
    do_read(4'h8, 0);

    // Fill past capacity; distinct REG0 per entry exposes ordering
    for (int i = 1; i <= DEPTH + 1; i++) begin
      do_write(4'h0, 32'(i) * 32'h01010101, 4'hF);
      do_write(4'hC, 32'(i), 4'b0001);
    end
    do_read(4'h8, 0);
    do_write(4'h8, 32'h80000000, 4'b0111);
    do_read(4'h8, 0);
    do_write(4'h8, 32'h80000000, 4'b1000);
    do_read(4'h8, 0);
    for (int i = 0; i < DEPTH; i++) do_pop();
    do_read(4'h8, 0);

    // Write-response backpressure with a second write queued behind it
    @(posedge clk); #1;
    bready = 1'b0;
    start_write(4'h4, 32'hCAFEF00D, 4'hF);
    wait_aw(1'b1);
    end_write();
    start_write(4'h0, 32'h01020304, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check1("bvalid_hold", bvalid, 1'b1);
      check1("aw_blocked", awready, 1'b0);
    end
    bready = 1'b1;
    wait_aw(1'b0);
    end_write();
    wait_b();
    $display("WR   backpressured pair done");

    // Read-data backpressure
    do_read(4'h4, 5);

    // Push and pop in the same cycle at count 3
    for (int i = 0; i < 3; i++) begin
      do_write(4'h0, 32'hA0 + 32'(i), 4'hF);
      do_write(4'hC, 32'h0, 4'hF);
    end
    @(posedge clk); #1;
    start_write(4'hC, 32'h5, 4'hF);
    wait_aw(1'b1);
    cmd_ready = 1'b1;
    end_write();
    cmd_ready = 1'b0;
    wait_b();
    $display("WR   push+pop same cycle, fifo=%0d", m_fifo.size());
    do_read(4'h8, 0);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      int op;
      logic [3:0] a;
      op = int'($urandom_range(0, 99));
      a = {2'($urandom_range(0, 3)), 2'b00};
      if (op < 45) do_write(a, $urandom, 4'($urandom_range(1, 15)));
      else if (op < 80) do_read(a, int'($urandom_range(0, 2)));
      else do_pop();
    end

    // Reset while entries are queued and a write response is outstanding
    while (m_fifo.size() != 0) do_pop();
    for (int i = 0; i < 3; i++) do_write(4'hC, 32'(i), 4'hF);
    @(posedge clk); #1;
    bready = 1'b0;
    start_write(4'h0, 32'hDEADBEEF, 4'hF);
    wait_aw(1'b1);
    end_write();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check1("midrst_cmd_valid", cmd_valid, 1'b0);
    check1("midrst_bvalid", bvalid, 1'b0);
    $display("RST  asserted mid-operation");
    repeat (3) @(posedge clk);
    #1;
    bready = 1'b1;
    rst_n = 1'b1;
    do_read(4'h8, 0);
    do_read(4'h0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
